// File: rtl/fft_sched_pkg.sv
// Shared state encoding and butterfly address math for the FFT butterfly schedulers.
package fft_sched_pkg;

  typedef enum logic [2:0] {IDLE, READ, LATCH, FIRE, WAIT, WRITE, DONE} state_t;

  function automatic int bfly_addr_a(input int s, input int k, input int n_log2);
    int half;
    int j;
    half = 1 << s;
    j = k & (half - 1);
    return (((k >> s) << (s + 1)) | j) & ((1 << n_log2) - 1);
  endfunction

  function automatic int bfly_addr_b(input int s, input int k, input int n_log2);
    return (bfly_addr_a(s, k, n_log2) + (1 << s)) & ((1 << n_log2) - 1);
  endfunction

  function automatic int twiddle_idx(input int s, input int k, input int n_log2);
    int j;
    j = k & ((1 << s) - 1);
    return (j << (n_log2 - 1 - s)) & ((1 << (n_log2 - 1)) - 1);
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly pair, twiddle index and last-butterfly flag from (stage, index).
module fft_addr_gen
  import fft_sched_pkg::*;
#(
  parameter int N_LOG2 = 3,
  parameter int S_W    = $clog2(N_LOG2)
) (
  input  logic [S_W-1:0]    s,
  input  logic [N_LOG2-2:0] k,
  output logic [N_LOG2-1:0] addr_a,
  output logic [N_LOG2-1:0] addr_b,
  output logic [N_LOG2-2:0] tw,
  output logic              last
);

  localparam int TW_W = N_LOG2 - 1;

  assign addr_a = N_LOG2'(bfly_addr_a(int'(s), int'(k), N_LOG2));
  assign addr_b = N_LOG2'(bfly_addr_b(int'(s), int'(k), N_LOG2));
  assign tw     = TW_W'(twiddle_idx(int'(s), int'(k), N_LOG2));
  assign last   = (s == S_W'(N_LOG2 - 1)) && (&k);

endmodule

// File: rtl/fft_butterfly_scheduler.sv
// Drives one shared butterfly unit through an in-place radix-2 DIT FFT.
//   state | meaning
//   IDLE  | waiting for start
//   READ  | RAM read addresses and twiddle index presented
//   LATCH | RAM data captured into butterfly operands
//   FIRE  | one-cycle butterfly launch, watchdog loaded
//   WAIT  | waiting for bf_done or watchdog expiry
//   WRITE | registered write of sum/difference pair
//   DONE  | one-cycle completion pulse
module fft_butterfly_scheduler
  import fft_sched_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int N_LOG2  = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [N_LOG2-1:0] mem_rd_addr_a,
  output logic [N_LOG2-1:0] mem_rd_addr_b,
  input  logic [WIDTH-1:0]  mem_rd_data_a,
  input  logic [WIDTH-1:0]  mem_rd_data_b,
  output logic              mem_wr_en,
  output logic [N_LOG2-1:0] mem_wr_addr_a,
  output logic [N_LOG2-1:0] mem_wr_addr_b,
  output logic [WIDTH-1:0]  mem_wr_data_a,
  output logic [WIDTH-1:0]  mem_wr_data_b,
  output logic [N_LOG2-2:0] tw_addr,
  output logic [WIDTH-1:0]  bf_a,
  output logic [WIDTH-1:0]  bf_b,
  output logic              bf_start,
  input  logic [WIDTH-1:0]  bf_out_add,
  input  logic [WIDTH-1:0]  bf_out_sub,
  input  logic              bf_done
);

  localparam int S_W  = $clog2(N_LOG2);
  localparam int K_W  = N_LOG2 - 1;
  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t            state, state_next;
  logic [S_W-1:0]    s;
  logic [K_W-1:0]    k;
  logic [WD_W-1:0]   wd;
  logic [N_LOG2-1:0] addr_a, addr_b;
  logic [K_W-1:0]    tw;
  logic              last;

  fft_addr_gen #(.N_LOG2(N_LOG2)) u_addr_gen (
    .s      (s),
    .k      (k),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .tw     (tw),
    .last   (last)
  );

  always_comb begin
    state_next    = state;
    busy          = (state != IDLE);
    done          = 1'b0;
    err           = 1'b0;
    bf_start      = 1'b0;
    mem_rd_addr_a = '0;
    mem_rd_addr_b = '0;
    tw_addr       = '0;
    case (state)
      IDLE: if (start) state_next = READ;
      READ: begin
        mem_rd_addr_a = addr_a;
        mem_rd_addr_b = addr_b;
        tw_addr       = tw;
        state_next    = LATCH;
      end
      LATCH: begin
        tw_addr    = tw;
        state_next = FIRE;
      end
      FIRE: begin
        tw_addr    = tw;
        bf_start   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        tw_addr = tw;
        // a result arriving on the expiry cycle is still accepted
        if (bf_done) begin
          state_next = WRITE;
        end else if (wd == '0) begin
          err        = 1'b1;
          state_next = IDLE;
        end
      end
      WRITE: state_next = last ? DONE : READ;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      s             <= '0;
      k             <= '0;
      wd            <= '0;
      bf_a          <= '0;
      bf_b          <= '0;
      mem_wr_en     <= 1'b0;
      mem_wr_addr_a <= '0;
      mem_wr_addr_b <= '0;
      mem_wr_data_a <= '0;
      mem_wr_data_b <= '0;
    end else begin
      state     <= state_next;
      mem_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            s <= '0;
            k <= '0;
          end
        end
        LATCH: begin
          bf_a <= mem_rd_data_a;
          bf_b <= mem_rd_data_b;
        end
        FIRE: wd <= WD_W'(TIMEOUT - 1);
        WAIT: begin
          if (bf_done) begin
            mem_wr_en     <= 1'b1;
            mem_wr_addr_a <= addr_a;
            mem_wr_addr_b <= addr_b;
            mem_wr_data_a <= bf_out_add;
            mem_wr_data_b <= bf_out_sub;
          end else if (wd != '0) begin
            wd <= wd - WD_W'(1);
          end
        end
        WRITE: begin
          if (last) begin
            s <= '0;
            k <= '0;
          end else if (&k) begin
            k <= '0;
            s <= s + S_W'(1);
          end else begin
            k <= k + K_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// Scoreboard bench: golden DIT write sequence queued per run, popped on each DUT write.
module tb_fft_butterfly_scheduler;

  localparam int WIDTH   = 16;
  localparam int N_LOG2  = 3;
  localparam int TIMEOUT = 8;
  localparam int NPTS    = 8;

  logic              clk = 1'b0;
  logic              rst, start, busy, done, err;
  logic [2:0]        mem_rd_addr_a, mem_rd_addr_b, mem_wr_addr_a, mem_wr_addr_b;
  logic [15:0]       mem_rd_data_a, mem_rd_data_b, mem_wr_data_a, mem_wr_data_b;
  logic              mem_wr_en, bf_start, bf_done;
  logic [1:0]        tw_addr;
  logic [15:0]       bf_a, bf_b, bf_out_add, bf_out_sub;

  always #5 clk = ~clk;

  fft_butterfly_scheduler #(.WIDTH(WIDTH), .N_LOG2(N_LOG2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .mem_rd_addr_a(mem_rd_addr_a), .mem_rd_addr_b(mem_rd_addr_b),
    .mem_rd_data_a(mem_rd_data_a), .mem_rd_data_b(mem_rd_data_b),
    .mem_wr_en(mem_wr_en), .mem_wr_addr_a(mem_wr_addr_a), .mem_wr_addr_b(mem_wr_addr_b),
    .mem_wr_data_a(mem_wr_data_a), .mem_wr_data_b(mem_wr_data_b),
    .tw_addr(tw_addr), .bf_a(bf_a), .bf_b(bf_b), .bf_start(bf_start),
    .bf_out_add(bf_out_add), .bf_out_sub(bf_out_sub), .bf_done(bf_done)
  );

  typedef struct {
    logic [2:0]  a;
    logic [2:0]  b;
    logic [1:0]  tw;
    logic [15:0] da;
    logic [15:0] db;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] tw_rom[4] = '{16'h7F00, 16'h5AA6, 16'h0081, 16'hA6A6};
  logic [15:0] ram[8];
  logic [15:0] img[8];
  logic        load_req;

  int checks = 0, failures = 0;
  int done_cnt = 0, err_cnt = 0, wr_cnt = 0;
  int lat, exp_gap;
  logic force_done, capture_first;
  logic [15:0] first_da, first_db;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Q1.7 complex butterfly: {a + b*w, a - b*w}
  function automatic logic [31:0] bfly(input logic [15:0] a, input logic [15:0] b, input logic [15:0] w);
    int ar, ai, br, bi, wr, wi, pr, pi;
    logic [7:0] sr, si, dr, di;
    ar = $signed(a[15:8]); ai = $signed(a[7:0]);
    br = $signed(b[15:8]); bi = $signed(b[7:0]);
    wr = $signed(w[15:8]); wi = $signed(w[7:0]);
    pr = (br * wr - bi * wi) >>> 7;
    pi = (br * wi + bi * wr) >>> 7;
    sr = 8'(ar + pr); si = 8'(ai + pi);
    dr = 8'(ar - pr); di = 8'(ai - pi);
    return {sr, si, dr, di};
  endfunction

  // synchronous RAM: read data valid the cycle after the address
  always @(posedge clk) begin
    if (load_req) begin
      ram <= img;
    end else if (mem_wr_en) begin
      ram[mem_wr_addr_a] <= mem_wr_data_a;
      ram[mem_wr_addr_b] <= mem_wr_data_b;
    end
    mem_rd_data_a <= ram[mem_rd_addr_a];
    mem_rd_data_b <= ram[mem_rd_addr_b];
  end

  // butterfly stub and output monitor
  initial begin : stub_mon
    int cnt, gap;
    logic holding, have_prev;
    logic [15:0] h_a, h_b;
    logic [1:0]  h_tw;
    logic [31:0] r;
    wr_t e;
    cnt = 0; gap = 0; holding = 1'b0; have_prev = 1'b0;
    bf_done = 1'b0; bf_out_add = '0; bf_out_sub = '0;
    h_a = '0; h_b = '0; h_tw = '0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (mem_wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(mem_wr_addr_a), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr_a", 32'(mem_wr_addr_a), 32'(e.a));
          chk("wr_addr_b", 32'(mem_wr_addr_b), 32'(e.b));
          chk("wr_data_a", 32'(mem_wr_data_a), 32'(e.da));
          chk("wr_data_b", 32'(mem_wr_data_b), 32'(e.db));
          chk("tw_at_fire", 32'(h_tw), 32'(e.tw));
          if (capture_first) begin
            first_da = mem_wr_data_a;
            first_db = mem_wr_data_b;
            capture_first = 1'b0;
          end
        end
      end
      if (!busy || mem_wr_en) holding = 1'b0;
      if (holding) begin
        chk("hold_bf_a", 32'(bf_a), 32'(h_a));
        chk("hold_bf_b", 32'(bf_b), 32'(h_b));
        chk("hold_tw_addr", 32'(tw_addr), 32'(h_tw));
      end
      if (!busy) have_prev = 1'b0;
      gap++;
      if (bf_start) begin
        if (have_prev && exp_gap != 0) chk("bf_gap", 32'(gap), 32'(exp_gap));
        have_prev = 1'b1;
        gap = 0;
        h_a = bf_a; h_b = bf_b; h_tw = tw_addr;
        holding = 1'b1;
        r = bfly(bf_a, bf_b, tw_rom[tw_addr]);
        bf_out_add = r[31:16];
        bf_out_sub = r[15:0];
        if (lat > 0) cnt = lat;
      end
      @(posedge clk);
      #1;
      bf_done = force_done;
      if (rst) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bf_done = 1'b1;
      end
    end
  end

  task automatic load_img();
    img[0] = 16'h0300; img[1] = 16'h0700; img[2] = 16'h0110; img[3] = 16'hF020;
    img[4] = 16'h1005; img[5] = 16'h0A0A; img[6] = 16'hE0F8; img[7] = 16'h0203;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // textbook DIT loop order: stage, group, position within group
  task automatic build_expected();
    logic [15:0] r[8];
    logic [31:0] o;
    wr_t e;
    int span, a, b, t;
    r = img;
    for (int st = 0; st < N_LOG2; st++) begin
      span = 1 << st;
      for (int g = 0; g < NPTS; g += 2 * span) begin
        for (int j = 0; j < span; j++) begin
          a = g + j;
          b = a + span;
          t = j * (NPTS / (2 * span));
          o = bfly(r[a], r[b], tw_rom[t]);
          r[a] = o[31:16];
          r[b] = o[15:0];
          e.a = 3'(a); e.b = 3'(b); e.tw = 2'(t); e.da = o[31:16]; e.db = o[15:0];
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic run_full(input int l, input int exp_cyc, input string tag);
    int cyc, d0, e0, w0;
    lat = l;
    exp_gap = 4 + l;
    load_img();
    build_expected();
    d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
    start = 1'b1;
    cyc = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 20);
    end
    chk({tag, "_cycles_to_done"}, 32'(cyc), 32'(exp_cyc));
    start = 1'b1;
    @(negedge clk);
    chk({tag, "_start_in_done_ignored"}, 32'(busy), 32'd0);
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_after_done"}, 32'(busy), 32'd0);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_write_count"}, 32'(wr_cnt - w0), 32'd12);
    chk({tag, "_err_pulses"}, 32'(err_cnt - e0), 32'd0);
    chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : global_bound
    #100000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "simulation time bound exceeded");
  end

  initial begin : main
    int cyc, n, w0, e0;
    rst = 1'b1; start = 1'b0; force_done = 1'b0; load_req = 1'b0;
    lat = 0; exp_gap = 0; capture_first = 1'b0;
    first_da = '0; first_db = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_pulses", 32'({done, err, bf_start, mem_wr_en}), 32'd0);
    chk("reset_addrs", 32'({mem_rd_addr_a, mem_rd_addr_b, mem_wr_addr_a, mem_wr_addr_b, tw_addr}), 32'd0);
    chk("reset_operands", {bf_a, bf_b}, 32'd0);
    chk("reset_wr_data", {mem_wr_data_a, mem_wr_data_b}, 32'd0);
    rst = 1'b0;

    w0 = wr_cnt;
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("spurious_done_idle", 32'(busy), 32'd0);
    chk("spurious_done_no_write", 32'(wr_cnt - w0), 32'd0);

    capture_first = 1'b1;
    run_full(1, 61, "lat1");
    chk("first_sum", 32'(first_da), 32'h0900);
    chk("first_diff", 32'(first_db), 32'hFD00);

    run_full(7, 133, "lat7");
    run_full(8, 145, "lat8_edge");

    lat = 0; exp_gap = 0;
    load_img();
    w0 = wr_cnt; e0 = err_cnt;
    start = 1'b1;
    cyc = 0;
    while (!err && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    chk("timeout_err_cycle", 32'(cyc), 32'd11);
    @(negedge clk);
    chk("timeout_busy_after", 32'(busy), 32'd0);
    chk("timeout_err_single", 32'(err), 32'd0);
    @(negedge clk);
    chk("timeout_err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("timeout_no_write", 32'(wr_cnt - w0), 32'd0);

    lat = 1; exp_gap = 5;
    load_img();
    build_expected();
    w0 = wr_cnt;
    start = 1'b1;
    n = 0; cyc = 0;
    while (n < 7 && cyc < 200) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (bf_start) n++;
    end
    @(negedge clk);
    chk("mid_rst_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_outputs", 32'(|{busy, done, err, mem_rd_addr_a, mem_rd_addr_b, mem_wr_en,
                                 mem_wr_addr_a, mem_wr_addr_b, mem_wr_data_a, mem_wr_data_b,
                                 tw_addr, bf_a, bf_b, bf_start}), 32'd0);
    chk("mid_rst_writes", 32'(wr_cnt - w0), 32'd6);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);

    run_full(1, 61, "rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
